// File: rtl/sync_cell_fifo_v2.sv
// sync_cell_fifo_v2: single-clock cell FIFO with whole-cell commit/release, drop, auto-close and length sideband
module sync_cell_fifo_v2 #(
  parameter int DWIDTH       = 8,
  parameter int AWIDTH       = 8,
  parameter int CWIDTH       = 2,
  parameter int H_AWIDTH     = AWIDTH - CWIDTH,
  parameter int ALFULL_TH    = 2,
  parameter int ALEMPTY_TH   = 2,
  parameter int OPEN_ADDRESS = 0,
  parameter int REG_OUT      = 0
) (
  input  logic                i_clk_sys,
  input  logic                i_rst_n,
  input  logic                i_wen,
  input  logic                i_weoc,
  input  logic                i_wdrop,
  input  logic [CWIDTH-1:0]   i_waddr,
  input  logic [DWIDTH-1:0]   i_wdata,
  output logic                o_full,
  output logic                o_alfull,
  input  logic                i_ren,
  input  logic                i_reoc,
  input  logic [CWIDTH-1:0]   i_raddr,
  output logic [DWIDTH-1:0]   o_rdata,
  output logic                o_rvalid,
  output logic [CWIDTH:0]     o_rlen,
  output logic                o_empty,
  output logic                o_alempty,
  output logic                o_overflow,
  output logic                o_underflow,
  output logic [H_AWIDTH:0]   o_cell_cnt
);
  localparam int NCELL_I = 1 << H_AWIDTH;
  localparam logic [H_AWIDTH:0] NCELL = (H_AWIDTH+1)'(NCELL_I);
  localparam logic [H_AWIDTH:0] AF_LIM = (H_AWIDTH+1)'(NCELL_I - ALFULL_TH);
  localparam logic [H_AWIDTH:0] AE_LIM = (H_AWIDTH+1)'(ALEMPTY_TH);
  logic [DWIDTH-1:0] mem [2**AWIDTH];
  logic [CWIDTH:0] len_tab [NCELL_I];
  logic [H_AWIDTH:0] wptr, rptr, wptr_n, rptr_n, cnt_n;
  logic [CWIDTH-1:0] wcnt, rcnt, wa, ra;
  logic wr_ok, rd_ok, close, rel, rd_v;
  logic [DWIDTH-1:0] rd_d;
  always_comb begin
    wr_ok  = i_wen & ~o_full & ~i_wdrop;
    rd_ok  = i_ren & ~o_empty;
    wa     = (OPEN_ADDRESS != 0) ? i_waddr : wcnt;
    ra     = (OPEN_ADDRESS != 0) ? i_raddr : rcnt;
    close  = wr_ok & (i_weoc | ((OPEN_ADDRESS == 0) & (&wcnt)));
    rel    = rd_ok & i_reoc;
    wptr_n = wptr + (H_AWIDTH+1)'(close);
    rptr_n = rptr + (H_AWIDTH+1)'(rel);
    cnt_n  = wptr_n - rptr_n;
  end
  always_ff @(posedge i_clk_sys) begin
    if (wr_ok) mem[{wptr[H_AWIDTH-1:0], wa}] <= i_wdata;
    if (close) len_tab[wptr[H_AWIDTH-1:0]] <= {1'b0, wa} + (CWIDTH+1)'(1);
  end
  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      wcnt        <= '0;
      rcnt        <= '0;
      o_full      <= 1'b0;
      o_alfull    <= 1'b0;
      o_empty     <= 1'b1;
      o_alempty   <= 1'b1;
      o_cell_cnt  <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
      rd_v        <= 1'b0;
      rd_d        <= '0;
    end else begin
      wptr        <= wptr_n;
      rptr        <= rptr_n;
      wcnt        <= (i_wdrop | close) ? '0 : wr_ok ? wcnt + CWIDTH'(1) : wcnt;
      rcnt        <= rel ? '0 : rd_ok ? rcnt + CWIDTH'(1) : rcnt;
      o_full      <= cnt_n == NCELL;
      o_alfull    <= cnt_n >= AF_LIM;
      o_empty     <= cnt_n == '0;
      o_alempty   <= cnt_n <= AE_LIM;
      o_cell_cnt  <= cnt_n;
      o_overflow  <= i_wen & o_full & ~i_wdrop;
      o_underflow <= i_ren & o_empty;
      rd_v        <= rd_ok;
      if (rd_ok) rd_d <= mem[{rptr[H_AWIDTH-1:0], ra}];
    end
  end
  assign o_rlen = o_empty ? '0 : len_tab[rptr[H_AWIDTH-1:0]];
  if (REG_OUT != 0) begin : g_reg
    always_ff @(posedge i_clk_sys) begin
      if (!i_rst_n) begin
        o_rdata  <= '0;
        o_rvalid <= 1'b0;
      end else begin
        o_rdata  <= rd_d;
        o_rvalid <= rd_v;
      end
    end
  end else begin : g_dir
    assign o_rdata  = rd_d;
    assign o_rvalid = rd_v;
  end
endmodule

// File: tb/tb_sync_cell_fifo_v2.sv
// tb_sync_cell_fifo_v2: directed scoreboard bench for sync_cell_fifo_v2
module tb_sync_cell_fifo_v2;
  logic i_clk_sys = 1'b0, i_rst_n, i_wen, i_weoc, i_wdrop, i_ren, i_reoc;
  logic [1:0] i_waddr, i_raddr;
  logic [7:0] i_wdata, o_rdata;
  logic o_full, o_alfull, o_rvalid, o_empty, o_alempty, o_overflow, o_underflow;
  logic [2:0] o_rlen;
  logic [6:0] o_cell_cnt;
  int total = 0, bad = 0, mcnt = 0;
  logic [7:0] sbq[$], pend[$], e_rd;
  int lq[$];
  sync_cell_fifo_v2 dut (
    .i_clk_sys(i_clk_sys), .i_rst_n(i_rst_n), .i_wen(i_wen), .i_weoc(i_weoc), .i_wdrop(i_wdrop),
    .i_waddr(i_waddr), .i_wdata(i_wdata), .o_full(o_full), .o_alfull(o_alfull), .i_ren(i_ren),
    .i_reoc(i_reoc), .i_raddr(i_raddr), .o_rdata(o_rdata), .o_rvalid(o_rvalid), .o_rlen(o_rlen),
    .o_empty(o_empty), .o_alempty(o_alempty), .o_overflow(o_overflow), .o_underflow(o_underflow),
    .o_cell_cnt(o_cell_cnt)
  );
  always #5 i_clk_sys = ~i_clk_sys;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge i_clk_sys) if (i_rst_n && o_rvalid) begin
    e_rd = (sbq.size() != 0) ? sbq.pop_front() : 8'hxx;
    chk("rdata", {24'd0, o_rdata}, {24'd0, e_rd});
  end
  task automatic cyc(input logic wen, weoc, wdrop, input logic [7:0] wd, input logic ren, reoc);
    logic ov, un, racc, cl;
    i_wen = wen; i_weoc = weoc; i_wdrop = wdrop; i_wdata = wd; i_ren = ren; i_reoc = reoc;
    ov = wen && !wdrop && mcnt == 64;
    un = ren && mcnt == 0;
    racc = ren && mcnt != 0;
    cl = 1'b0;
    if (wdrop) pend.delete();
    else if (wen && mcnt != 64) begin
      pend.push_back(wd);
      if (weoc || pend.size() == 4) begin
        lq.push_back(pend.size());
        foreach (pend[k]) sbq.push_back(pend[k]);
        pend.delete();
        cl = 1'b1;
      end
    end
    if (racc && reoc) void'(lq.pop_front());
    mcnt = mcnt + int'(cl) - int'(racc && reoc);
    @(negedge i_clk_sys);
    i_wen = 0; i_weoc = 0; i_wdrop = 0; i_ren = 0; i_reoc = 0;
    chk("overflow", o_overflow, ov);
    chk("underflow", o_underflow, un);
    chk("rvalid", o_rvalid, racc);
    chk("cell_cnt", o_cell_cnt, mcnt);
    chk("empty", o_empty, mcnt == 0);
    chk("full", o_full, mcnt == 64);
    chk("alfull", o_alfull, mcnt >= 62);
    chk("alempty", o_alempty, mcnt <= 2);
    chk("rlen", o_rlen, (lq.size() != 0) ? lq[0] : 0);
  endtask
  initial begin
    i_rst_n = 0; i_wen = 0; i_weoc = 0; i_wdrop = 0; i_ren = 0; i_reoc = 0;
    i_waddr = 0; i_raddr = 0; i_wdata = 0;
    repeat (3) @(negedge i_clk_sys);
    chk("rst_empty", o_empty, 1);
    chk("rst_alempty", o_alempty, 1);
    chk("rst_full", o_full, 0);
    chk("rst_alfull", o_alfull, 0);
    chk("rst_cnt", o_cell_cnt, 0);
    chk("rst_rlen", o_rlen, 0);
    chk("rst_rvalid", o_rvalid, 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_unf", o_underflow, 0);
    i_rst_n = 1;
    cyc(1, 0, 0, 8'hA1, 0, 0);
    cyc(1, 0, 0, 8'hB2, 0, 0);
    chk("partial_hidden", o_empty, 1);
    cyc(1, 1, 0, 8'hC3, 0, 0);
    chk("rlen3", o_rlen, 3);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 1);
    chk("drained_rlen", o_rlen, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 8'h10 + 8'(i), 0, 0);
    chk("auto_rlen4", o_rlen, 4);
    cyc(1, 0, 0, 8'h55, 0, 0);
    chk("next_cell_open", o_cell_cnt, 1);
    cyc(1, 1, 0, 8'h66, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, i == 3);
    chk("second_rlen2", o_rlen, 2);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 8'h71, 0, 0);
    cyc(1, 0, 0, 8'h72, 0, 0);
    cyc(1, 0, 1, 8'hEE, 0, 0);
    cyc(1, 1, 0, 8'h73, 0, 0);
    chk("drop_rlen1", o_rlen, 1);
    cyc(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 64; i++) cyc(1, 1, 0, 8'(i), 0, 0);
    chk("filled", o_full, 1);
    cyc(1, 1, 0, 8'hFF, 0, 0);
    chk("ovf_cnt64", o_cell_cnt, 64);
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 59; i++) cyc(0, 0, 0, 0, 1, 1);
    cyc(1, 1, 0, 8'h99, 1, 1);
    chk("same_cycle_cnt5", o_cell_cnt, 5);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    chk("sbq_left", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
